seg7_scan: RTL and testbench

Downstream display stage for the clock counters. Takes four BCD digits (seconds units, seconds tens, minutes units, minutes tens) and drives a 4-digit common-anode 7-segment display by time-multiplexing. Inputs are snapshotted once per frame so a counter update mid-scan never shows a torn value. A short blanking window at the start of each digit slot suppresses ghosting.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_scan.sv | 99 +++++++++
 tb/tb_seg7_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 4-digit multiplexed 7-segment display.
// Segment patterns are active-low, bit order g..a in [6:0].
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int DIG_N = 4;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] AN_OFF   = 4'hF;
    localparam logic [6:0] SEG_DASH = 7'b011_1111;

    // Entry k is the glyph for BCD code k (9 listed first in the packed concatenation).
    localparam logic [9:0][6:0] GLYPH = {
        7'b001_0000,  // 9
        7'b000_0000,  // 8
        7'b111_1000,  // 7
        7'b000_0010,  // 6
        7'b001_0010,  // 5
        7'b001_1001,  // 4
        7'b011_0000,  // 3
        7'b010_0100,  // 2
        7'b111_1001,  // 1
        7'b100_0000   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes (10..15) render as a single dash on segment g.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assigning a default first guarantees every path drives seg, so no latch is inferred.
        seg = SEG_DASH;
        if (code < 4'd10) begin
            seg = GLYPH[code];
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display with per-frame input snapshot
// and a per-slot blanking window. Optional macro SEG7_ZERO_BLANK_EN suppresses a leading zero on digit 3.
module seg7_scan #(
    parameter int         SCAN_DIV  = 50000,
    parameter int         BLANK_CYC = 16,
    parameter logic [3:0] DP_MASK   = 4'b0100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    output logic [3:0] an,
    output logic [7:0] seg
);

    import seg7_pkg::*;

    localparam int PCNT_W = $clog2(SCAN_DIV);
    localparam int BCNT_W = $clog2(BLANK_CYC + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYC - 1);

    logic [PCNT_W-1:0]      pcnt;
    logic [BCNT_W-1:0]      bcnt;
    logic [1:0]             idx;
    state_t                 state;
    logic [DIG_N-1:0][3:0]  snap;

    logic                   tick;
    logic [3:0]             cur_code;
    logic [6:0]             cur_glyph;
    logic [3:0]             lit_an;
    logic                   zero_blank;

    assign tick     = (pcnt == PCNT_LAST);
    assign cur_code = snap[idx];
    assign lit_an   = ~(4'b0001 << idx);

`ifdef SEG7_ZERO_BLANK_EN
    assign zero_blank = (idx == 2'd3) && (snap[3] == 4'd0);
`else
    assign zero_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (cur_glyph)
    );

    // Outputs are computed from the pre-edge state/idx/snap, giving one register stage of latency.
    // NOTE: non-blocking assignments let every register here sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            bcnt  <= '0;
            idx   <= 2'd0;
            state <= BLANK;
            // NOTE: the snapshot is only four nibbles and must read 0000 after reset, so it is reset explicitly.
            snap  <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
        end else begin
            if (state == SHOW) begin
                an  <= zero_blank ? AN_OFF : lit_an;
                seg <= {~DP_MASK[idx], cur_glyph};
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end

            pcnt <= tick ? '0 : pcnt + 1'b1;

            if (tick) begin
                state <= BLANK;
                bcnt  <= '0;
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap <= {dig3, dig2, dig1, dig0};
                end
            end else begin
                case (state)
                    BLANK: begin
                        if (bcnt == BCNT_LAST) begin
                            state <= SHOW;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                    SHOW:    state <= SHOW;
                    default: state <= BLANK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed test of seg7_scan with SCAN_DIV=8, BLANK_CYC=2; slot s of a frame starting at edge F
// is visible on the outputs after edges F+8s+3 .. F+8s+8.
module tb_seg7_scan;

    import seg7_pkg::*;

`ifdef SEG7_ZERO_BLANK_EN
    localparam logic [3:0] AN_SLOT3_ZERO = 4'hF;
`else
    localparam logic [3:0] AN_SLOT3_ZERO = 4'h7;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [3:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .DP_MASK   (4'b0100)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dig0 (dig0),
        .dig1 (dig1),
        .dig2 (dig2),
        .dig3 (dig3),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        check({tag, ".an"}, 32'(an), 32'(exp_an));
        check({tag, ".seg"}, 32'(seg), 32'(exp_seg));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic go(input int target);
        step(target - cyc);
    endtask

    initial begin
        dig0 = 4'd3;
        dig1 = 4'd2;
        dig2 = 4'd1;
        dig3 = 4'd0;
        rst  = 1'b1;
        step(3);
        check_disp("reset", 4'hF, 8'hFF);
        check("reset.idx", 32'(dut.idx), 32'd0);
        check("reset.state", 32'(dut.state), 32'(BLANK));
        rst = 1'b0;
        cyc = 0;

        // First frame: reset snapshot 0000 with blank windows
        go(1);   check_disp("blank0_a", 4'hF, 8'hFF);
        go(2);   check_disp("blank0_b", 4'hF, 8'hFF);
        go(3);   check_disp("slot0_first", 4'hE, 8'hC0);
        go(8);   check_disp("slot0_last", 4'hE, 8'hC0);
        go(9);   check_disp("slot1_blank", 4'hF, 8'hFF);
        go(11);  check_disp("slot1_snap0", 4'hD, 8'hC0);

        // Second frame: live snapshot 3,2,1,0
        go(35);  check_disp("f2_slot0", 4'hE, 8'hB0);
        go(41);  check_disp("f2_slot1_blank", 4'hF, 8'hFF);
        go(43);  check_disp("f2_slot1", 4'hD, 8'hA4);
        go(51);  check_disp("f2_slot2_dp", 4'hB, 8'h79);

        // Tearing: inputs change mid-frame, display holds the snapshot
        dig0 = 4'd4;
        dig3 = 4'd7;
        go(59);  check_disp("tear_slot3_old", AN_SLOT3_ZERO, 8'hC0);
        go(67);  check_disp("tear_slot0_new", 4'hE, 8'h99);
        dig1 = 4'hC;
        go(75);  check_disp("tear_slot1_old", 4'hD, 8'hA4);
        go(91);  check_disp("f3_slot3_7", 4'h7, 8'hF8);

        // Invalid code renders a dash
        go(107); check_disp("invalid_dash", 4'hD, 8'hBF);

        // Reset in the middle of SHOW on idx 2
        go(115); check_disp("pre_reset", 4'hB, 8'h79);
        check("pre_reset.state", 32'(dut.state), 32'(SHOW));
        rst = 1'b1;
        step(1);
        check("mid_reset.state", 32'(dut.state), 32'(BLANK));
        check("mid_reset.idx", 32'(dut.idx), 32'd0);
        check("mid_reset.pcnt", 32'(dut.pcnt), 32'd0);
        check_disp("mid_reset", 4'hF, 8'hFF);
        rst = 1'b0;
        cyc = 0;
        step(1); check_disp("post_reset_blank", 4'hF, 8'hFF);
        go(3);   check_disp("post_reset_slot0", 4'hE, 8'hC0);
        go(11);  check_disp("post_reset_slot1", 4'hD, 8'hC0);
        go(19);  check_disp("post_reset_slot2", 4'hB, 8'h40);

        // Leading-zero digit 3
        dig3 = 4'd0;
        go(27);  check_disp("post_reset_slot3", AN_SLOT3_ZERO, 8'hC0);
        go(35);  check_disp("zb_slot0_unaffected", 4'hE, 8'h99);
        for (int c = 57; c <= 64; c++) begin
            go(c);
            check($sformatf("zb_slot3_an_c%0d", c), 32'(an), 32'((c < 59) ? 4'hF : AN_SLOT3_ZERO));
        end
        go(59 + 0 * cyc);
        dig3 = 4'd5;
        go(123); check_disp("zb_slot3_5", 4'h7, 8'h92);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
